// File: rtl/id_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : id_inst_queue
// Brief    : Instruction queue between IF and ID. Circular buffer of
//            {PC, inst} entries with valid/ready handshakes on both sides,
//            flush, and head-entry register-index / BREAK decode.
// Revision : 1.0 - initial release
// ============================================================================
module id_inst_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       left_valid,
    output logic                       left_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [31:0]                in_inst,
    output logic                       right_valid,
    input  logic                       right_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [31:0]                out_inst,
    output logic [4:0]                 reg_index1,
    output logic [4:0]                 reg_index2,
    output logic [4:0]                 wreg_index,
    output logic                       is_break,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             CW       = $clog2(DEPTH+1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    // Storage is deliberately left out of reset; only written slots are read.
    logic [PC_W-1:0] pc_mem_q   [DEPTH];
    logic [31:0]     inst_mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic push;
    logic pop;

    // Handshake status comes only from registered occupancy, so there is no
    // combinational path from right_ready to left_ready.
    assign left_ready  = (count_q != FULL_CNT);
    assign right_valid = (count_q != '0);
    assign count       = count_q;

    // Flush kills any concurrent transfer on either side.
    assign push = left_valid & left_ready & ~flush;
    assign pop  = right_valid & right_ready & ~flush;

    // Next-state for pointers and occupancy; flush returns to the empty state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry write; untouched slots keep their contents.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= in_pc;
            inst_mem_q[wr_ptr_q] <= in_inst;
        end
    end

    // Head entry is read straight from storage: no write-to-read bypass.
    assign out_pc   = pc_mem_q[rd_ptr_q];
    assign out_inst = inst_mem_q[rd_ptr_q];

    // Head decode: stores and conditional branches read rd through the
    // second read port; bl writes the link register r1.
    always_comb begin
        reg_index1 = out_inst[9:5];
        reg_index2 = out_inst[14:10];
        wreg_index = out_inst[4:0];
        if ((out_inst[31:22] == 10'h0A4) || (out_inst[31:22] == 10'h0A5) ||
            (out_inst[31:22] == 10'h0A6) ||
            ((out_inst[31:26] >= 6'h16) && (out_inst[31:26] <= 6'h1B))) begin
            reg_index2 = out_inst[4:0];
        end
        if (out_inst[31:26] == 6'h15) begin
            wreg_index = 5'd1;
        end
    end

    assign is_break = right_valid & (out_inst[31:15] == 17'h00054);

endmodule
`default_nettype wire

// File: tb/tb_id_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_inst_queue
// Brief    : Self-checking bench for id_inst_queue (DEPTH=4): table-driven
//            handshake vectors plus hand-written decode and async-reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_inst_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam logic [31:0] INST_MASK = 32'hDEADBEEF;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        left_valid;
    logic        left_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        right_valid;
    logic        right_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [4:0]  reg_index1;
    logic [4:0]  reg_index2;
    logic [4:0]  wreg_index;
    logic        is_break;
    logic [2:0]  count;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        fl;
        logic        lv;
        logic [31:0] pc;
        logic        rr;
        logic [2:0]  exp_cnt;
        logic        exp_lr;
        logic        exp_rv;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    id_inst_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .left_valid  (left_valid),
        .left_ready  (left_ready),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .right_valid (right_valid),
        .right_ready (right_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .reg_index1  (reg_index1),
        .reg_index2  (reg_index2),
        .wreg_index  (wreg_index),
        .is_break    (is_break),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic lv, input logic [31:0] pc, input logic rr,
                       input logic [2:0] cnt, input logic lr, input logic rv, input logic [31:0] hpc);
        vec_t v;
        v.fl = fl; v.lv = lv; v.pc = pc; v.rr = rr;
        v.exp_cnt = cnt; v.exp_lr = lr; v.exp_rv = rv; v.exp_pc = hpc;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, take the edge, settle past it.
    task automatic cyc(input logic fl, input logic lv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic rr);
        flush       = fl;
        left_valid  = lv;
        in_pc       = pc;
        in_inst     = inst;
        right_ready = rr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        flush       = 1'b0;
        left_valid  = 1'b0;
        right_ready = 1'b0;
        in_pc       = '0;
        in_inst     = '0;

        // fl lv pc rr | count lr rv head_pc
        // fill to full, then a 5th offer that must be refused
        add(0, 1, 32'h1C000000, 0, 3'd1, 1, 1, 32'h1C000000);
        add(0, 1, 32'h1C000004, 0, 3'd2, 1, 1, 32'h1C000000);
        add(0, 1, 32'h1C000008, 0, 3'd3, 1, 1, 32'h1C000000);
        add(0, 1, 32'h1C00000C, 0, 3'd4, 0, 1, 32'h1C000000);
        add(0, 1, 32'h1C000010, 0, 3'd4, 0, 1, 32'h1C000000);
        // full: pop and offer together -> offer dropped
        add(0, 1, 32'h1C000010, 1, 3'd3, 1, 1, 32'h1C000004);
        add(0, 0, 32'h00000000, 1, 3'd2, 1, 1, 32'h1C000008);
        // streaming at count 2 for 6 cycles, pointers wrap
        add(0, 1, 32'h1C000020, 1, 3'd2, 1, 1, 32'h1C00000C);
        add(0, 1, 32'h1C000024, 1, 3'd2, 1, 1, 32'h1C000020);
        add(0, 1, 32'h1C000028, 1, 3'd2, 1, 1, 32'h1C000024);
        add(0, 1, 32'h1C00002C, 1, 3'd2, 1, 1, 32'h1C000028);
        add(0, 1, 32'h1C000030, 1, 3'd2, 1, 1, 32'h1C00002C);
        add(0, 1, 32'h1C000034, 1, 3'd2, 1, 1, 32'h1C000030);
        // up to 3, then flush with concurrent push and pop
        add(0, 1, 32'h1C000038, 0, 3'd3, 1, 1, 32'h1C000030);
        add(1, 1, 32'h1C00003C, 1, 3'd0, 1, 0, 32'h0);
        add(0, 1, 32'h1C000040, 0, 3'd1, 1, 1, 32'h1C000040);
        // drain, pop on empty ignored, push on empty with rr=1 is not bypassed
        add(0, 0, 32'h00000000, 1, 3'd0, 1, 0, 32'h0);
        add(0, 0, 32'h00000000, 1, 3'd0, 1, 0, 32'h0);
        add(0, 1, 32'h1C000044, 1, 3'd1, 1, 1, 32'h1C000044);
        add(0, 0, 32'h00000000, 1, 3'd0, 1, 0, 32'h0);

        // reset state
        #2;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_left_ready", 32'(left_ready), 32'd1);
        chk("reset_right_valid", 32'(right_valid), 32'd0);
        chk("reset_is_break", 32'(is_break), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].fl, vecs[i].lv, vecs[i].pc, vecs[i].pc ^ INST_MASK, vecs[i].rr);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
            chk($sformatf("v%0d_left_ready", i), 32'(left_ready), 32'(vecs[i].exp_lr));
            chk($sformatf("v%0d_right_valid", i), 32'(right_valid), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv) begin
                chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].exp_pc);
                chk($sformatf("v%0d_out_inst", i), out_inst, vecs[i].exp_pc ^ INST_MASK);
            end
        end

        // head decode: st.w
        cyc(0, 1, 32'h1C000100, 32'h29800C85, 0);
        chk("stw_reg_index1", 32'(reg_index1), 32'd4);
        chk("stw_reg_index2", 32'(reg_index2), 32'd5);
        chk("stw_wreg_index", 32'(wreg_index), 32'd5);
        chk("stw_is_break", 32'(is_break), 32'd0);
        // bl replaces st.w at the head
        cyc(0, 1, 32'h1C000104, 32'h54000400, 1);
        chk("bl_wreg_index", 32'(wreg_index), 32'd1);
        chk("bl_reg_index1", 32'(reg_index1), 32'd0);
        chk("bl_reg_index2", 32'(reg_index2), 32'd1);
        // beq: second read index from inst[4:0]
        cyc(0, 1, 32'h1C000108, 32'h58000C85, 1);
        chk("beq_reg_index2", 32'(reg_index2), 32'd5);
        chk("beq_wreg_index", 32'(wreg_index), 32'd5);
        // ordinary ALU op: second read index from inst[14:10]
        cyc(0, 1, 32'h1C00010C, 32'h00100C85, 1);
        chk("alu_reg_index2", 32'(reg_index2), 32'd3);
        chk("alu_reg_index1", 32'(reg_index1), 32'd4);
        // break at head, then two more behind it -> count 3
        cyc(0, 1, 32'h1C000110, 32'h002A0000, 1);
        chk("brk_is_break", 32'(is_break), 32'd1);
        chk("brk_out_pc", out_pc, 32'h1C000110);
        cyc(0, 1, 32'h1C000114, 32'h00100C85, 0);
        cyc(0, 1, 32'h1C000118, 32'h00100C85, 0);
        chk("pre_reset_count", 32'(count), 32'd3);
        chk("pre_reset_is_break", 32'(is_break), 32'd1);

        // asynchronous reset pulse between edges
        left_valid  = 1'b0;
        right_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_right_valid", 32'(right_valid), 32'd0);
        chk("async_left_ready", 32'(left_ready), 32'd1);
        chk("async_is_break", 32'(is_break), 32'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_count", 32'(count), 32'd0);
        cyc(0, 1, 32'h1C000200, 32'h00000000, 0);
        chk("post_reset_push_count", 32'(count), 32'd1);
        chk("post_reset_push_pc", out_pc, 32'h1C000200);
        cyc(0, 0, 32'h0, 32'h0, 1);
        chk("final_right_valid", 32'(right_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
